// File: rtl/video_text_ram.sv
// Text-cell video RAM: CPU word port with registers, scrolled display
// lookup pipeline and a hardware fill engine.
module video_text_ram #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int CELL_W = 8
) (
  input  logic              clk_cpu_i,
  input  logic              cpu_reset_n_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_write_data_i,
  input  logic [3:0]        cpu_write_mask_i,
  output logic [31:0]       cpu_read_data_o,
  input  logic              pxl_valid_i,
  input  logic [7:0]        pxl_col_i,
  input  logic [7:0]        pxl_row_i,
  output logic              pxl_valid_o,
  output logic [CELL_W-1:0] pxl_data_o,
  output logic              busy_o
);

  localparam int LANES = 32 / CELL_W;
  localparam int WORDS = (COLS * ROWS + LANES - 1) / LANES;
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LW = $clog2(LANES);

  localparam logic [31:0] WORDS_U = 32'(WORDS);
  localparam logic [8:0]  ROWS9   = 9'(ROWS);
  localparam logic [8:0]  COLS9   = 9'(COLS);
  localparam logic [15:0] COLS16  = 16'(COLS);
  localparam logic [AW-1:0] LAST  = AW'(WORDS - 1);

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_t;

  logic [31:0] mem [WORDS];

  state_t            state, state_n;
  logic [AW-1:0]     fill_cnt, cnt_n;
  logic [CELL_W-1:0] fill_val, val_n;
  logic              fill_we;
  logic [31:0]       fill_word;
  logic [7:0]        scroll;

  logic              sel_reg;
  logic [12:0]       widx;
  logic [31:0]       widx32;
  logic              in_range;
  logic [AW-1:0]     cpu_word;
  logic              ram_wr;
  logic              reg_wr;
  logic              fill_start;
  logic [31:0]       rd_next;

  assign sel_reg    = cpu_addr_i[15];
  assign widx       = cpu_addr_i[14:2];
  assign widx32     = {19'b0, widx};
  assign in_range   = widx32 < WORDS_U;
  assign cpu_word   = AW'(widx32);
  assign reg_wr     = sel_reg && (|cpu_write_mask_i);
  assign ram_wr     = !sel_reg && (|cpu_write_mask_i)
                      && in_range && (state == S_IDLE);
  assign fill_start = reg_wr && (widx[1:0] == 2'd1);
  assign fill_word  = {LANES{fill_val}};
  assign busy_o     = (state == S_FILL);

  // Single write port: the engine and the CPU never write together
  always_ff @(posedge clk_cpu_i) begin
    if (fill_we) begin
      mem[fill_cnt] <= fill_word;
    end else if (ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (cpu_write_mask_i[b]) begin
          mem[cpu_word][8*b +: 8] <= cpu_write_data_i[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_next = '0;
    if (sel_reg) begin
      unique case (widx[1:0])
        2'd0:    rd_next = {24'b0, scroll};
        2'd2:    rd_next = {31'b0, busy_o};
        default: rd_next = '0;
      endcase
    end else if (in_range && (state == S_IDLE)) begin
      rd_next = mem[cpu_word];
    end
  end

  always_ff @(posedge clk_cpu_i or negedge cpu_reset_n_i) begin
    if (!cpu_reset_n_i) begin
      cpu_read_data_o <= '0;
      scroll          <= '0;
    end else begin
      cpu_read_data_o <= rd_next;
      if (reg_wr && (widx[1:0] == 2'd0) && cpu_write_mask_i[0]
          && ({1'b0, cpu_write_data_i[7:0]} < ROWS9)) begin
        scroll <= cpu_write_data_i[7:0];
      end
    end
  end

  always_ff @(posedge clk_cpu_i or negedge cpu_reset_n_i) begin
    if (!cpu_reset_n_i) begin
      state    <= S_IDLE;
      fill_cnt <= '0;
      fill_val <= '0;
    end else begin
      state    <= state_n;
      fill_cnt <= cnt_n;
      fill_val <= val_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = fill_cnt;
    val_n   = fill_val;
    fill_we = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fill_start) begin
          state_n = S_FILL;
          cnt_n   = '0;
          val_n   = cpu_write_data_i[CELL_W-1:0];
        end
      end
      S_FILL: begin
        fill_we = 1'b1;
        if (fill_cnt == LAST) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = fill_cnt + AW'(1);
        end
      end
    endcase
  end

  logic [8:0]  row_sum;
  logic [8:0]  row_wrap;
  logic [7:0]  phys_row;
  logic        req_oob;

  always_comb begin
    row_sum  = {1'b0, pxl_row_i} + {1'b0, scroll};
    row_wrap = row_sum - ROWS9;
    phys_row = (row_sum >= ROWS9) ? row_wrap[7:0] : row_sum[7:0];
    req_oob  = ({1'b0, pxl_col_i} >= COLS9)
               || ({1'b0, pxl_row_i} >= ROWS9);
  end

  logic          s1_valid, s1_oob;
  logic [7:0]    s1_col, s1_prow;
  logic          s2_valid, s2_oob;
  logic [AW-1:0] s2_word;
  logic [LW-1:0] s2_lane;
  logic [15:0]   cell_idx;
  logic [31:0]   lane_word;
  logic [CELL_W-1:0] lane_cell;

  assign cell_idx  = {8'b0, s1_prow} * COLS16 + {8'b0, s1_col};
  assign lane_word = mem[s2_word];
  assign lane_cell = CELL_W'(lane_word >> (32'(s2_lane) * 32'(CELL_W)));

  // Out-of-range requests carry a flag instead of a clamped address
  always_ff @(posedge clk_cpu_i or negedge cpu_reset_n_i) begin
    if (!cpu_reset_n_i) begin
      s1_valid    <= 1'b0;
      s1_oob      <= 1'b0;
      s1_col      <= '0;
      s1_prow     <= '0;
      s2_valid    <= 1'b0;
      s2_oob      <= 1'b0;
      s2_word     <= '0;
      s2_lane     <= '0;
      pxl_valid_o <= 1'b0;
      pxl_data_o  <= '0;
    end else begin
      s1_valid    <= pxl_valid_i;
      s1_oob      <= req_oob;
      s1_col      <= pxl_col_i;
      s1_prow     <= phys_row;
      s2_valid    <= s1_valid;
      s2_oob      <= s1_oob;
      s2_word     <= AW'(cell_idx >> LW);
      s2_lane     <= cell_idx[LW-1:0];
      pxl_valid_o <= s2_valid;
      if (s2_valid) begin
        pxl_data_o <= s2_oob ? '0 : lane_cell;
      end
    end
  end

  logic unused;
  assign unused = ^{cpu_addr_i[31:16], cpu_addr_i[1:0], row_wrap[8]};

endmodule

// File: doc/video_text_ram.md
Name: video_text_ram

Overview:
- Parametrised successor to the fixed 4 KiB video RAM. Stores a COLS x ROWS text-cell grid of CELL_W-bit cells, packed into 32-bit words.
- CPU port: byte-masked word reads and writes, plus control/status registers.
- Display port: cell lookup by (col,row) with hardware vertical scroll (row offset with wrap).
- Hardware fill engine clears or fills the whole grid without CPU loops. Sits between the CPU bus decoder and the VGA text renderer, on the single system clock.

Parameters:
- COLS, 80, cells per row (1..255).
- ROWS, 30, rows per screen (1..255).
- CELL_W, 8, bits per cell; legal values are 8 or 16.
- LANES, 32/CELL_W (derived, localparam), cells per 32-bit word.
- WORDS, ceil(COLS*ROWS/LANES) (derived, localparam), storage depth in words.

Ports:
- clk_cpu_i  in  1  system clock; all logic is on this clock.
- cpu_reset_n_i  in  1  asynchronous active-low reset.
- cpu_addr_i  in  32  byte address. Bit 15 = 0 selects RAM; bit 15 = 1 selects registers. Word index is [14:2].
- cpu_write_data_i  in  32  write data.
- cpu_write_mask_i  in  4  byte write enables; 0 = read.
- cpu_read_data_o  out  32  read data, 1-cycle latency.
- pxl_valid_i  in  1  lookup request.
- pxl_col_i  in  8  column.
- pxl_row_i  in  8  screen row (pre-scroll).
- pxl_valid_o  out  1  pxl_valid_i delayed 3 cycles.
- pxl_data_o  out  CELL_W  cell value.
- busy_o  out  1  fill engine active.

Behaviour:
- Reset (async, cpu_reset_n_i = 0):
  - cpu_read_data_o = 0, pxl_data_o = 0, pxl_valid_o = 0, busy_o = 0.
  - scroll = 0, FSM = IDLE, fill counter = 0.
  - RAM contents are not cleared.
- Cell packing: cell n lives in word n/LANES, lane n%LANES. Lane 0 occupies the LSBs (little-endian, matching the CPU byte order).
- CPU RAM access:
  - Read returns the full word in the cycle after the address.
  - Write updates only the masked bytes.
  - Word index >= WORDS: write ignored, read returns 0.
  - Simultaneous read and write to the same word returns the old data.
- Registers (word index in [3:2]):
  - 0 = CTRL. Bits [7:0] hold scroll. A write with mask[0] = 1 and value < ROWS updates scroll; a value >= ROWS is ignored.
  - 1 = FILL. A write with any mask bit set, while in IDLE, latches bits [CELL_W-1:0] as the fill value and enters FILL. A write while busy is ignored.
  - 2 = STATUS. Bit 0 = busy; all other bits read 0.
  - 3: reads 0; writes ignored.
- Fill FSM:
  - IDLE -> FILL on a FILL register write.
  - In FILL, one word per cycle, indices 0..WORDS-1, each written with the fill value replicated into all lanes.
  - After word WORDS-1 is written: FILL -> IDLE, counter = 0.
  - busy_o = 1 for exactly WORDS cycles.
  - While in FILL, the CPU port is owned by the engine: CPU RAM writes are dropped and CPU RAM reads return 0. Register access stays live.
- Reset mid-fill: immediate return to IDLE with busy_o = 0. RAM is left partially filled.
- Display pipeline (fixed latency 3; one request accepted every cycle):
  - S1: register col/row/valid; phys_row = row + scroll, minus ROWS if >= ROWS. Computed with compare/subtract, no divider.
  - S2: cell index = phys_row*COLS + col; register word address and lane.
  - S3: RAM port B read, then lane select into pxl_data_o.
  - col >= COLS or row >= ROWS: pxl_data_o = 0 for that request; valid is still propagated.
  - When pxl_valid_o = 0, pxl_data_o holds its previous value.
  - Display reads during a fill return old or new data per word, with no corruption.
- A scroll change takes effect on the request accepted in the cycle after the CTRL write.

Test Plan:
- Reset, then a CPU read of word 0 -> cpu_read_data_o = 0 and busy_o = 0. Write 0x44434241 to addr 0 with mask 4'hF, then read -> 0x44434241. Display (col 2, row 0) -> 0x43, exactly 3 cycles after pxl_valid_i.
- Write addr 4 with mask 4'b0010 and data 0x0000AA00 over prior 0x11223344 -> readback 0x1122AA44.
- Write FILL = 0x20 -> busy_o high for exactly 600 cycles (80x30/4). Then every word reads 0x20202020. A CPU RAM write issued mid-fill is lost; a second FILL write mid-fill is ignored.
- Write cell (col 0, phys row 5) = 0x7E. Set CTRL scroll = 5 -> display (col 0, row 0) = 0x7E. Set scroll = 29 -> display row 1 maps to phys row 0. A CTRL write of 30 leaves scroll at 29.
- Display row 30 or col 80 -> pxl_data_o = 0 with pxl_valid_o = 1. CPU read at word index 600 -> 0.
- Assert cpu_reset_n_i for 1 cycle mid-fill -> busy_o = 0 asynchronously, words already written keep the fill value, later words are unchanged. Repeat with CELL_W = 16, COLS = 40, ROWS = 25 -> busy for 500 cycles, and lane select returns 16-bit cells.
